sound_arbiter: RTL and testbench
================================

# sound_arbiter

Shares the single piezo tone generator among three requesters: alarm, timer-expiry and key-click. It arbitrates by fixed priority, sequences each requester's note pattern, and drives the tone generator's scale index and enable. It sits between the clock/alarm/timer control logic and the tone generator. The tone generator produces the square wave from `NOTE` (scale 0–7, do→high do) whenever `TONE_EN` is high.

## Interface
Parameters:
- `NOTE_CYC`, default 500000: cycles per alarm melody note (0.5 s at 1 MHz).
- `BEEP_CYC`, default 200000: timer beep on-time, and also the gap between timer beeps.
- `CLICK_CYC`, default 50000: key-click duration.
- `TIMER_BEEPS`, default 3: number of beeps per timer event, range 1–7.

Ports:
- `CLK_1MHZ`  in  1  system clock, 1 MHz.
- `RESETN`  in  1  asynchronous, active-low reset.
- `ALARM_REQ`  in  1  level; alarm melody plays while high.
- `TIMER_REQ`  in  1  one-cycle pulse; timer expired.
- `KEY_REQ`  in  1  one-cycle pulse; key pressed.
- `NOTE`  out  3  scale index to the tone generator.
- `TONE_EN`  out  1  tone generator enable.
- `GNT`  out  3  one-hot owner of the generator: [2] alarm, [1] timer, [0] key. All zero when idle.
- `BUSY`  out  1  high when the state is not IDLE.

## Operation
- All outputs are registered. On reset: `NOTE`=0, `TONE_EN`=0, `GNT`=0, `BUSY`=0, state=IDLE, timer-pending flag cleared, duration counter=0, beep counter=0.
- Duration counter is 20 bits. Every duration parameter must be ≥1 and <2^20. A phase lasting N cycles holds its outputs for exactly N clock edges.
- Priority: alarm > timer > key.
- States: IDLE, ALARM, T_ON, T_OFF, CLICK.
- IDLE:
  - If `ALARM_REQ` is high, go to ALARM with `NOTE`=0.
  - Else, if the timer is pending or `TIMER_REQ` is high, go to T_ON with beep count 1.
  - Else, if `KEY_REQ` is high, go to CLICK.
- ALARM:
  - `TONE_EN`=1, `GNT`=100.
  - `NOTE` advances 0→1→…→7→0 every `NOTE_CYC` cycles.
  - When `ALARM_REQ` is low at an edge, leave at that edge: go to T_ON if the timer is pending, else IDLE. The melody restarts at note 0 on the next entry.
- T_ON:
  - `NOTE`=7, `TONE_EN`=1, `GNT`=010, for `BEEP_CYC` cycles.
  - At the end, if beep count = `TIMER_BEEPS`, clear pending and go to IDLE. There is no trailing gap.
  - Otherwise go to T_OFF.
- T_OFF:
  - `TONE_EN`=0, `GNT`=010, for `BEEP_CYC` cycles.
  - Then increment the beep count and go to T_ON.
- CLICK:
  - `NOTE`=4, `TONE_EN`=1, `GNT`=001, for `CLICK_CYC` cycles, then IDLE.
- Timer-pending flag:
  - Set by `TIMER_REQ` in any state except T_ON/T_OFF. In those states `TIMER_REQ` is ignored; events do not stack.
  - Cleared only when a full sequence completes.
- Preemption:
  - `ALARM_REQ` high in T_ON, T_OFF or CLICK moves to ALARM at that edge.
  - A preempted timer sequence stays pending and restarts from beep 1 after the alarm.
  - A preempted click is discarded.
- `TIMER_REQ` during CLICK sets pending. The click finishes, then T_ON is entered from IDLE on the next edge.
- `KEY_REQ` is accepted only in IDLE with no higher-priority request. Otherwise it is dropped and not queued.

## Timing
- Latency: a request sampled high at edge k changes the outputs after edge k, a 1-cycle registered latency.
- Simultaneous events at the same edge are resolved by priority. The losers behave as follows:
  - `TIMER_REQ` is latched as pending.
  - `KEY_REQ` is dropped.
- `ALARM_REQ` falling and `TIMER_REQ` pulsing at the same edge in ALARM: go directly to T_ON.
- At least 1 IDLE cycle separates CLICK→T_ON and T_ON(last)→any state. ALARM→T_ON is direct, with no IDLE cycle.
- `RESETN` low at any time immediately forces the reset values, including in the middle of a note or beep. Pending events are lost.
- `NOTE` wraps from 7 to 0 in ALARM without a gap cycle.

## Test plan
Run with `NOTE_CYC`=8, `BEEP_CYC`=4, `CLICK_CYC`=2, `TIMER_BEEPS`=3.
- Alarm melody: hold `ALARM_REQ` for 70 cycles.
  - Required: `NOTE` steps 0..7 at 8 cycles each, then wraps to 0.
  - Required: `TONE_EN`=1 and `GNT`=100 throughout.
  - Required: IDLE with all outputs 0 one edge after release.
- Timer sequence: pulse `TIMER_REQ`.
  - Required: `TONE_EN` pattern 4 on / 4 off / 4 on / 4 off / 4 on, with `NOTE`=7 and `GNT`=010.
  - Required: `BUSY` falls after 20 cycles.
- Timer preemption: pulse `TIMER_REQ`, raise `ALARM_REQ` 6 cycles later, drop it 20 cycles later.
  - Required: `GNT` goes 010→100→010.
  - Required: the full 3-beep sequence restarts after the alarm.
- Key handling: pulse `KEY_REQ` in IDLE, then again during a timer beep.
  - Required: the first pulse gives a 2-cycle `NOTE`=4 click with `GNT`=001.
  - Required: the second pulse is dropped and has no effect on the timer pattern.
- Simultaneous events and reset: pulse `TIMER_REQ` and `KEY_REQ` on the same edge.
  - Required: timer wins and no click follows.
  - Then assert `RESETN` low mid-beep. Required: all outputs 0 immediately, and no beep resumes after release.

Source files
------------

// File: rtl/sound_arbiter.sv
// ============================================================================
// sound_arbiter : fixed-priority sharing of the piezo tone generator among
//                 alarm melody, timer beeps and key clicks.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module sound_arbiter #(
    parameter int unsigned NOTE_CYC    = 500000,
    parameter int unsigned BEEP_CYC    = 200000,
    parameter int unsigned CLICK_CYC   = 50000,
    parameter int unsigned TIMER_BEEPS = 3
) (
    input  logic       CLK_1MHZ,
    input  logic       RESETN,
    input  logic       ALARM_REQ,
    input  logic       TIMER_REQ,
    input  logic       KEY_REQ,
    output logic [2:0] NOTE,
    output logic       TONE_EN,
    output logic [2:0] GNT,
    output logic       BUSY
);

    localparam logic [19:0] c_NOTE_LAST  = 20'(NOTE_CYC - 1);
    localparam logic [19:0] c_BEEP_LAST  = 20'(BEEP_CYC - 1);
    localparam logic [19:0] c_CLICK_LAST = 20'(CLICK_CYC - 1);
    localparam logic [2:0]  c_BEEPS      = 3'(TIMER_BEEPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALARM = 3'd1,
        S_T_ON  = 3'd2,
        S_T_OFF = 3'd3,
        S_CLICK = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  note_q,  note_d;
    logic [19:0] dur_q,   dur_d;
    logic [2:0]  beep_q,  beep_d;
    logic        pend_q,  pend_d;
    logic        tone_q,  tone_d;
    logic [2:0]  gnt_q,   gnt_d;
    logic        busy_q,  busy_d;

    always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            note_q  <= 3'd0;
            dur_q   <= 20'd0;
            beep_q  <= 3'd0;
            pend_q  <= 1'b0;
            tone_q  <= 1'b0;
            gnt_q   <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            beep_q  <= beep_d;
            pend_q  <= pend_d;
            tone_q  <= tone_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        dur_d   = dur_q + 20'd1;
        beep_d  = beep_q;
        pend_d  = pend_q;
        tone_d  = 1'b0;
        gnt_d   = 3'b000;

        // A running timer sequence ignores new expiries; they never stack.
        if (TIMER_REQ && state_q != S_T_ON && state_q != S_T_OFF) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                dur_d = 20'd0;
                if (ALARM_REQ) begin
                    state_d = S_ALARM;
                    note_d  = 3'd0;
                end else if (pend_q || TIMER_REQ) begin
                    state_d = S_T_ON;
                    beep_d  = 3'd1;
                end else if (KEY_REQ) begin
                    state_d = S_CLICK;
                end
            end
            S_ALARM: begin
                if (!ALARM_REQ) begin
                    dur_d   = 20'd0;
                    beep_d  = 3'd1;
                    state_d = (pend_q || TIMER_REQ) ? S_T_ON : S_IDLE;
                end else if (dur_q == c_NOTE_LAST) begin
                    dur_d  = 20'd0;
                    note_d = note_q + 3'd1;
                end
            end
            S_T_ON: begin
                if (ALARM_REQ) begin
                    state_d = S_ALARM;
                    dur_d   = 20'd0;
                    note_d  = 3'd0;
                end else if (dur_q == c_BEEP_LAST) begin
                    dur_d = 20'd0;
                    if (beep_q == c_BEEPS) begin
                        state_d = S_IDLE;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_T_OFF;
                    end
                end
            end
            S_T_OFF: begin
                if (ALARM_REQ) begin
                    state_d = S_ALARM;
                    dur_d   = 20'd0;
                    note_d  = 3'd0;
                end else if (dur_q == c_BEEP_LAST) begin
                    dur_d   = 20'd0;
                    beep_d  = beep_q + 3'd1;
                    state_d = S_T_ON;
                end
            end
            S_CLICK: begin
                if (ALARM_REQ) begin
                    state_d = S_ALARM;
                    dur_d   = 20'd0;
                    note_d  = 3'd0;
                end else if (dur_q == c_CLICK_LAST) begin
                    dur_d   = 20'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                dur_d   = 20'd0;
            end
        endcase

        // Outputs are registered, so decode them from the next state.
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_ALARM: begin
                tone_d = 1'b1;
                gnt_d  = 3'b100;
            end
            S_T_ON: begin
                note_d = 3'd7;
                tone_d = 1'b1;
                gnt_d  = 3'b010;
            end
            S_T_OFF: begin
                note_d = 3'd7;
                gnt_d  = 3'b010;
            end
            S_CLICK: begin
                note_d = 3'd4;
                tone_d = 1'b1;
                gnt_d  = 3'b001;
            end
            default: begin
                note_d = 3'd0;
            end
        endcase
    end

    assign NOTE    = note_q;
    assign TONE_EN = tone_q;
    assign GNT     = gnt_q;
    assign BUSY    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_arbiter.sv
// ============================================================================
// tb_sound_arbiter : directed self-checking bench for sound_arbiter.
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sound_arbiter;

    logic       clk;
    logic       rst_n;
    logic       alarm_req;
    logic       timer_req;
    logic       key_req;
    logic [2:0] note;
    logic       tone_en;
    logic [2:0] gnt;
    logic       busy;

    int n_assert;
    int n_fail;

    sound_arbiter #(
        .NOTE_CYC    (8),
        .BEEP_CYC    (4),
        .CLICK_CYC   (2),
        .TIMER_BEEPS (3)
    ) u_dut (
        .CLK_1MHZ  (clk),
        .RESETN    (rst_n),
        .ALARM_REQ (alarm_req),
        .TIMER_REQ (timer_req),
        .KEY_REQ   (key_req),
        .NOTE      (note),
        .TONE_EN   (tone_en),
        .GNT       (gnt),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pack {NOTE, TONE_EN, GNT, BUSY} into one comparable word.
    function automatic logic [31:0] ev(input int n, input bit t, input logic [2:0] g, input bit b);
        logic [2:0] n3;
        n3 = n[2:0];
        return {24'd0, n3, t, g, b};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {24'd0, note, tone_en, gnt, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for position i of a 3-beep sequence (4 on / 4 off).
    function automatic logic [31:0] timer_exp(input int i);
        return ev(7, ((i / 4) % 2) == 0, 3'b010, 1'b1);
    endfunction

    // Steps through positions first..19 of a timer sequence, optionally pulsing
    // KEY_REQ before position key_at, then checks the return to idle.
    task automatic timer_pattern(input string tag, input int first, input int key_at);
        for (int i = first; i < 20; i++) begin
            key_req = (i == key_at);
            step();
            timer_req = 1'b0;
            key_req   = 1'b0;
            check($sformatf("%s_t%0d", tag, i), obs_vec(), timer_exp(i));
        end
        step();
        check($sformatf("%s_end", tag), obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        alarm_req = 1'b0;
        timer_req = 1'b0;
        key_req   = 1'b0;

        step();
        check("reset_out", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
        rst_n = 1'b1;
        step();
        check("idle_after_reset", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));

        // Alarm melody: 8 cycles per note, wrap 7 -> 0 without a gap.
        alarm_req = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            check($sformatf("alarm_c%0d", i), obs_vec(), ev((i / 8) % 8, 1'b1, 3'b100, 1'b1));
        end
        alarm_req = 1'b0;
        step();
        check("alarm_release", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));

        // Plain timer sequence.
        timer_req = 1'b1;
        timer_pattern("timer", 0, -1);

        // Timer preempted in its first gap, restarts from beep 1 after alarm.
        timer_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            timer_req = 1'b0;
            check($sformatf("pre_t%0d", i), obs_vec(), timer_exp(i));
        end
        alarm_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("pre_alarm%0d", k), obs_vec(), ev(k / 8, 1'b1, 3'b100, 1'b1));
        end
        alarm_req = 1'b0;
        timer_pattern("resume", 0, -1);

        // Key click in idle, then a key pulse during a beep is dropped.
        key_req = 1'b1;
        step();
        key_req = 1'b0;
        check("click_c0", obs_vec(), ev(4, 1'b1, 3'b001, 1'b1));
        step();
        check("click_c1", obs_vec(), ev(4, 1'b1, 3'b001, 1'b1));
        step();
        check("click_done", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
        timer_req = 1'b1;
        timer_pattern("keybeep", 0, 2);
        step();
        check("keybeep_noclick", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));

        // Timer during a click: click finishes, one idle cycle, then beeps.
        key_req = 1'b1;
        step();
        key_req   = 1'b0;
        timer_req = 1'b1;
        check("cl2_c0", obs_vec(), ev(4, 1'b1, 3'b001, 1'b1));
        step();
        timer_req = 1'b0;
        check("cl2_c1", obs_vec(), ev(4, 1'b1, 3'b001, 1'b1));
        step();
        check("cl2_gap", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
        step();
        check("cl2_t0", obs_vec(), timer_exp(0));
        timer_pattern("cl2", 1, -1);

        // Simultaneous timer and key: timer wins, no click afterwards.
        timer_req = 1'b1;
        key_req   = 1'b1;
        step();
        timer_req = 1'b0;
        key_req   = 1'b0;
        check("simul_t0", obs_vec(), timer_exp(0));
        timer_pattern("simul", 1, -1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("simul_idle%0d", i), obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
        end

        // Reset mid-beep clears outputs at once; no beep resumes.
        timer_req = 1'b1;
        step();
        timer_req = 1'b0;
        step();
        check("prerst_beep", obs_vec(), timer_exp(1));
        rst_n = 1'b0;
        #1;
        check("rst_immediate", obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("postrst_idle%0d", i), obs_vec(), ev(0, 1'b0, 3'b000, 1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
